serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//   Multi-cycle bit-serial add/subtract unit for the ALU datapath. Subtract is the
//   primary mode (a - b = a + ~b + 1). One 1-bit full-adder slice plus a carry flop
//   processes one bit per clock, LSB first. A start/ready/done handshake lets a
//   controller launch an operation and collect the result and flags.
// PARAMETERS
//   WIDTH  32  operand/result width in bits (>= 2)
// PORTS
//   clk       in   1      rising-edge clock, the only clock
//   reset     in   1      synchronous, active-high reset
//   start     in   1      launch request; accepted only when ready=1
//   op        in   1      0 = add (a+b), 1 = subtract (a-b); sampled with start
//   a         in   WIDTH  operand A; sampled with start
//   b         in   WIDTH  operand B; sampled with start
//   ready     out  1      high in IDLE only; unit can accept start
//   done      out  1      one-cycle pulse: result/flags updated this cycle
//   result    out  WIDTH  sum or difference, held until next done
//   carry     out  1      add: carry-out; sub: borrow (= ~carry-out, 1 when a<b unsigned)
//   overflow  out  1      two's-complement signed overflow
//   zero      out  1      result == 0
// BEHAVIOUR
//   - Reset (synchronous, active-high): state=IDLE, ready=1, done=0, result=0,
//     carry=0, overflow=0, zero=0, bit counter=0. Dominates all other inputs.
//   - FSM: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: ready=1. On edge with start=1: latch a, b, op; invert b if op=1;
//       carry flop = op; counter=0; -> RUN. ready drops the following cycle.
//     RUN: each edge computes s = a_sh[0]^b_sh[0]^c, c' = majority(a_sh[0],b_sh[0],c);
//       shifts a_sh/b_sh right; shifts s into MSB of sum shift register; counter++.
//       After WIDTH edges in RUN -> DONE.
//     DONE: result, carry, overflow, zero registered; done=1 for exactly one cycle;
//       next edge -> IDLE (ready=1).
//   - Latency: done is high in the cycle beginning WIDTH+1 edges after the edge
//     that sampled start; throughput one op per WIDTH+2 cycles.
//   - Flags: carry = final c (add) or ~final c (sub). overflow = (a[W-1]==b_eff[W-1])
//     && (result[W-1]!=a[W-1]), b_eff = b or ~b. zero = ~|result.
//   - Arithmetic modulo 2^WIDTH; no saturation.
//   - start while ready=0 (RUN or DONE) is ignored; a/b/op changes after acceptance
//     have no effect on the operation in progress.
//   - start held high through DONE: second op accepted on the first IDLE edge.
//   - Result/flag outputs change only in DONE cycle (or reset); stable otherwise.
//   - Reset mid-operation: operation abandoned, no done pulse, outputs return to
//     reset values, ready=1 in the cycle after the reset edge.
// TESTING (WIDTH=8)
//   1. reset high 2 cycles -> ready=1, done=0, result=0, carry/overflow/zero=0.
//   2. op=1,a=5,b=3,start 1 cycle -> done pulse 9 edges later, result=8'h02,
//      carry=0, overflow=0, zero=0; ready=1 next cycle.
//   3. op=1,a=3,b=5 -> result=8'hFE, carry(borrow)=1, overflow=0;
//      op=1,a=8'h80,b=1 -> result=8'h7F, overflow=1, carry=0.
//   4. op=0,a=8'hFF,b=8'h01 -> result=0, carry=1, zero=1, overflow=0;
//      op=0,a=8'h7F,b=1 -> result=8'h80, overflow=1.
//   5. start pulsed with new a/b 3 cycles into RUN -> ignored; result matches first op;
//      exactly one done pulse.
//   6. reset asserted 4 cycles into RUN -> no done, outputs 0, ready=1 next cycle;
//      subsequent op=1,a=8'h2A,b=8'h2A -> result=0, zero=1, carry=0.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit: one full-adder slice plus a carry flop, LSB first.
// Results and flags are registered on the edge that leaves DONE, together with a one-cycle done pulse.
module serial_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_op;
  logic             r_aMsb;
  logic             r_bEffMsb;

  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;
  logic             r_zero;

  logic             w_s;
  logic             w_cOut;
  logic             w_accept;
  logic             w_lastBit;

  assign w_s       = r_aSh[0] ^ r_bSh[0] ^ r_c;
  assign w_cOut    = (r_aSh[0] & r_bSh[0]) | (r_aSh[0] & r_c) | (r_bSh[0] & r_c);
  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_lastBit = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_RUN;
      S_RUN:   if (w_lastBit) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == S_IDLE);
  end

  // Subtract is folded into the load: b is inverted and the carry flop seeded with 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_aSh     <= '0;
      r_bSh     <= '0;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_c       <= 1'b0;
      r_op      <= 1'b0;
      r_aMsb    <= 1'b0;
      r_bEffMsb <= 1'b0;
    end else if (w_accept) begin
      r_aSh     <= a;
      r_bSh     <= op ? ~b : b;
      r_cnt     <= '0;
      r_c       <= op;
      r_op      <= op;
      r_aMsb    <= a[WIDTH-1];
      r_bEffMsb <= op ? ~b[WIDTH-1] : b[WIDTH-1];
    end else if (r_state == S_RUN) begin
      r_aSh <= r_aSh >> 1;
      r_bSh <= r_bSh >> 1;
      r_sum <= {w_s, r_sum[WIDTH-1:1]};
      r_c   <= w_cOut;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Visible outputs only move here (or on reset), so a controller can read them any time.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done     <= 1'b0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_DONE) begin
        r_done     <= 1'b1;
        r_result   <= r_sum;
        r_carry    <= r_op ? ~r_c : r_c;
        r_overflow <= (r_aMsb == r_bEffMsb) && (r_sum[WIDTH-1] != r_aMsb);
        r_zero     <= ~|r_sum;
      end
    end
  end

  assign done     = r_done;
  assign result   = r_result;
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign zero     = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH=8: fixed vectors, handshake corner
// sequences and random operations compared against an arithmetic reference model.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expRes;
    logic         expC;
    logic         expV;
    logic         expZ;
  } vec_t;

  vec_t vecs[7];

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain unsigned/signed integer arithmetic, result taken modulo 2^W.
  function automatic logic [W+2:0] refModel(input logic iOp, input logic [W-1:0] iA, input logic [W-1:0] iB);
    int ua;
    int ub;
    int sa;
    int sb;
    int r;
    int sr;
    logic [W-1:0] res;
    logic c;
    logic v;
    ua = int'(iA);
    ub = int'(iB);
    sa = $signed(iA);
    sb = $signed(iB);
    if (iOp) begin
      r  = ua - ub;
      sr = sa - sb;
      c  = (ua < ub);
    end else begin
      r  = ua + ub;
      sr = sa + sb;
      c  = (r > (1 << W) - 1);
    end
    res = r[W-1:0];
    v   = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    return {res, c, v, (res == '0)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Presents one launch request for a single cycle; returns at the negedge just after the sampling edge.
  task automatic applyStimulus(input logic iOp, input logic [W-1:0] iA, input logic [W-1:0] iB);
    @(negedge clk);
    op    = iOp;
    a     = iA;
    b     = iB;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int lat, input int limit);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runOp(input string name, input logic iOp, input logic [W-1:0] iA, input logic [W-1:0] iB,
                       input logic [W-1:0] expRes, input logic expC, input logic expV, input logic expZ);
    logic [W-1:0] held;
    int lat;
    held = result;
    applyStimulus(iOp, iA, iB);
    repeat (4) @(negedge clk);
    checkOutput({name, " ready low in run"}, 32'(ready), 32'd0);
    checkOutput({name, " result held in run"}, 32'(result), 32'(held));
    waitDone(lat, 16);
    if (lat > 0) lat = lat + 4;
    checkOutput({name, " latency"}, 32'(lat), 32'(W + 1));
    checkOutput({name, " result"}, 32'(result), 32'(expRes));
    checkOutput({name, " carry"}, 32'(carry), 32'(expC));
    checkOutput({name, " overflow"}, 32'(overflow), 32'(expV));
    checkOutput({name, " zero"}, 32'(zero), 32'(expZ));
    @(negedge clk);
    checkOutput({name, " done width"}, 32'(done), 32'd0);
    checkOutput({name, " ready after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    logic [W+2:0] exp;
    logic         rOp;
    logic [W-1:0] rA;
    logic [W-1:0] rB;
    int           d1;
    int           d2;
    int           nDone;
    logic [W-1:0] r1;
    logic [W-1:0] r2;

    vecs[0] = '{1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset ready", 32'(ready), 32'd1);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", 32'(result), 32'd0);
    checkOutput("reset flags", {29'd0, carry, overflow, zero}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].expRes, vecs[i].expC, vecs[i].expV, vecs[i].expZ);
    end

    // start held high through DONE; operand change after acceptance only affects the second op
    @(negedge clk);
    op    = 1'b0;
    a     = 8'd3;
    b     = 8'd4;
    start = 1'b1;
    @(negedge clk);
    a  = 8'd10;
    d1 = -1;
    d2 = -1;
    r1 = '0;
    r2 = '0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == W + 2) start = 1'b0;
      if (done === 1'b1) begin
        if (d1 < 0) begin
          d1 = k;
          r1 = result;
        end else if (d2 < 0) begin
          d2 = k;
          r2 = result;
        end
      end
    end
    checkOutput("held start first latency", 32'(d1), 32'(W + 1));
    checkOutput("held start first result", 32'(r1), 32'd7);
    checkOutput("held start second latency", 32'(d2), 32'(2 * W + 3));
    checkOutput("held start second result", 32'(r2), 32'd14);

    // start with new operands three cycles into RUN must be ignored
    applyStimulus(1'b0, 8'd10, 8'd20);
    repeat (3) @(negedge clk);
    op    = 1'b1;
    a     = 8'd99;
    b     = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nDone = 0;
    d1    = -1;
    r1    = '0;
    for (int k = 5; k <= 25; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        nDone++;
        if (d1 < 0) begin
          d1 = k;
          r1 = result;
        end
      end
    end
    checkOutput("ignored start done count", 32'(nDone), 32'd1);
    checkOutput("ignored start latency", 32'(d1), 32'(W + 1));
    checkOutput("ignored start result", 32'(r1), 32'd30);

    // reset four cycles into RUN abandons the operation
    applyStimulus(1'b0, 8'hF0, 8'h20);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid reset ready", 32'(ready), 32'd1);
    checkOutput("mid reset done", 32'(done), 32'd0);
    checkOutput("mid reset result", 32'(result), 32'd0);
    checkOutput("mid reset flags", {29'd0, carry, overflow, zero}, 32'd0);
    nDone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) nDone++;
    end
    checkOutput("mid reset no done", 32'(nDone), 32'd0);
    runOp("after reset", 1'b1, 8'h2A, 8'h2A, 8'h00, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rOp = 1'($urandom_range(0, 1));
      rA  = W'($urandom);
      rB  = W'($urandom);
      exp = refModel(rOp, rA, rB);
      runOp($sformatf("rand%0d op%0d %0h %0h", i, rOp, rA, rB), rOp, rA, rB,
            exp[W+2:3], exp[2], exp[1], exp[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
